fetch_unit: RTL and testbench

//   Parametrised instruction fetch unit for the single-cycle MIPS core; successor to ifu.

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-cycle MIPS instruction fetch.
// Holds the PC, reads the instruction combinationally from a word-addressed ROM,
// and selects the next PC (hold / jr / jump / branch / sequential). A candidate PC
// that is misaligned or beyond the memory moves the unit into a sticky FAULT state
// that only reset clears.
module fetch_unit #(
    parameter int          IMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter string       IMEM_INIT  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        is_branch,
    input  logic        is_jump,
    input  logic        is_jr,
    input  logic [15:0] imm16,
    input  logic [25:0] addr26,
    input  logic [31:0] jr_target,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam int AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    // Instruction memory: read-only from the core.
    logic [31:0] mem [0:IMEM_WORDS-1];

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_fault_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_cand;
    logic        w_reject;
    logic        w_update;
    logic [AW-1:0] w_idx;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{imm16[15]}}, imm16, 2'b00};
    // Only unstalled cycles in RUN evaluate (and possibly commit) a candidate.
    assign w_update   = (r_state == S_RUN) && !stall;
    // In RUN the PC is always in range, so the low address bits are a valid index.
    assign w_idx      = r_pc[AW+1:2];

    // Next-PC candidate: jr beats jump beats branch beats sequential.
    always_comb begin
        w_cand = w_pc_plus4;
        if (is_jr)
            w_cand = jr_target;
        else if (is_jump)
            w_cand = {w_pc_plus4[31:28], addr26, 2'b00};
        else if (is_branch)
            w_cand = w_pc_plus4 + w_br_off;
    end

    // Reject misaligned targets (jr only) and targets past the last memory word.
    always_comb begin
        w_reject = (w_cand[1:0] != 2'b00) ||
                   ({2'b00, w_cand[31:2]} >= 32'(IMEM_WORDS));
    end

    // State register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_RUN;
        else
            r_state <= w_state_nxt;
    end

    // Next state: FAULT is sticky, entered on a rejected update.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (w_update && w_reject) w_state_nxt = S_FAULT;
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // State-dependent outputs: FAULT presents a nop.
    always_comb begin
        fault       = (r_state == S_FAULT);
        instruction = 32'h0;
        if (r_state == S_RUN)
            instruction = mem[w_idx];
    end

    // PC and fault-address registers: commit accepted candidates, capture rejected ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_fault_pc <= 32'h0;
        end else if (w_update) begin
            if (w_reject)
                r_fault_pc <= w_cand;
            else
                r_pc <= w_cand;
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign fault_pc = r_fault_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench with a scoreboard of expected fetch state.
// Two instances share stimulus: a default 256-word unit and a 4-word unit
// used for the end-of-memory scenarios.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, is_branch, is_jump, is_jr;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic [31:0] jr_target;

    logic [31:0] instr_a, pc_a, pc4_a, fpc_a;
    logic        flt_a;
    logic [31:0] instr_b, pc_b, pc4_b, fpc_b;
    logic        flt_b;

    localparam logic [31:0] WA = 32'hA0A0_0001;
    localparam logic [31:0] WB = 32'hB1B1_0002;
    localparam logic [31:0] WC = 32'hC2C2_0003;
    localparam logic [31:0] WD = 32'hD3D3_0004;

    typedef struct {
        int          unit;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        flt;
        logic [31:0] fpc;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    fetch_unit #(.IMEM_WORDS(256), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .is_branch(is_branch),
        .is_jump(is_jump), .is_jr(is_jr), .imm16(imm16), .addr26(addr26),
        .jr_target(jr_target), .instruction(instr_a), .pc(pc_a),
        .pc_plus4(pc4_a), .fault(flt_a), .fault_pc(fpc_a)
    );

    fetch_unit #(.IMEM_WORDS(4), .RESET_PC(32'h0)) dut4 (
        .clk(clk), .reset(reset), .stall(stall), .is_branch(is_branch),
        .is_jump(is_jump), .is_jr(is_jr), .imm16(imm16), .addr26(addr26),
        .jr_target(jr_target), .instruction(instr_b), .pc(pc_b),
        .pc_plus4(pc4_b), .fault(flt_b), .fault_pc(fpc_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, record the expected post-edge state, then
    // pop it after the edge and compare against the selected unit.
    task automatic step(input int unit, input logic rst, input logic stl,
                        input logic jr, input logic jmp, input logic br,
                        input logic [15:0] imm, input logic [25:0] a26,
                        input logic [31:0] jrt, input logic [31:0] e_pc,
                        input logic [31:0] e_instr, input logic e_flt,
                        input logic [31:0] e_fpc);
        exp_t e;
        @(negedge clk);
        reset = rst; stall = stl; is_jr = jr; is_jump = jmp; is_branch = br;
        imm16 = imm; addr26 = a26; jr_target = jrt;
        e.unit = unit; e.pc = e_pc; e.instr = e_instr; e.flt = e_flt; e.fpc = e_fpc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.unit == 0) begin
            chk("pc", pc_a, e.pc);
            chk("instr", instr_a, e.instr);
            chk("fault", {31'h0, flt_a}, {31'h0, e.flt});
            chk("fault_pc", fpc_a, e.fpc);
            chk("pc_plus4", pc4_a, e.pc + 32'd4);
        end else begin
            chk("pc4u", pc_b, e.pc);
            chk("instr4u", instr_b, e.instr);
            chk("fault4u", {31'h0, flt_b}, {31'h0, e.flt});
            chk("fault_pc4u", fpc_b, e.fpc);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; is_branch = 1'b0; is_jump = 1'b0; is_jr = 1'b0;
        imm16 = 16'h0; addr26 = 26'h0; jr_target = 32'h0;
        dut.mem[0] = WA; dut.mem[1] = WB; dut.mem[2] = WC; dut.mem[3] = WD;
        dut4.mem[0] = WA; dut4.mem[1] = WB; dut4.mem[2] = WC; dut4.mem[3] = WD;

        //   unit rst stl jr jmp br imm      a26      jrt        pc      instr flt fpc
        // Reset state
        step(0, 1, 0, 0, 0, 0, 16'h0,    26'h0,   32'h0,     32'h0,  WA,   0,  32'h0);
        // Sequential fetch
        step(0, 0, 0, 0, 0, 0, 16'h0,    26'h0,   32'h0,     32'h4,  WB,   0,  32'h0);
        step(0, 0, 0, 0, 0, 0, 16'h0,    26'h0,   32'h0,     32'h8,  WC,   0,  32'h0);
        step(0, 0, 0, 0, 0, 0, 16'h0,    26'h0,   32'h0,     32'hC,  WD,   0,  32'h0);
        // Jumps
        step(0, 0, 0, 0, 1, 0, 16'h0,    26'h2,   32'h0,     32'h8,  WC,   0,  32'h0);
        step(0, 0, 0, 0, 1, 0, 16'h0,    26'h0,   32'h0,     32'h0,  WA,   0,  32'h0);
        step(0, 0, 0, 0, 1, 0, 16'h0,    26'h2,   32'h0,     32'h8,  WC,   0,  32'h0);
        // Backward branch and self loop
        step(0, 0, 0, 0, 0, 1, 16'hFFFD, 26'h0,   32'h0,     32'h0,  WA,   0,  32'h0);
        step(0, 0, 0, 0, 0, 0, 16'h0,    26'h0,   32'h0,     32'h4,  WB,   0,  32'h0);
        step(0, 0, 0, 0, 0, 0, 16'h0,    26'h0,   32'h0,     32'h8,  WC,   0,  32'h0);
        step(0, 0, 0, 0, 0, 1, 16'hFFFF, 26'h0,   32'h0,     32'h8,  WC,   0,  32'h0);
        // Jump beats branch
        step(0, 0, 0, 0, 1, 1, 16'hFFFD, 26'h1,   32'h0,     32'h4,  WB,   0,  32'h0);
        // Stall holds despite a jump, then release
        step(0, 0, 1, 0, 1, 0, 16'h0,    26'h0,   32'h0,     32'h4,  WB,   0,  32'h0);
        step(0, 0, 1, 0, 1, 0, 16'h0,    26'h0,   32'h0,     32'h4,  WB,   0,  32'h0);
        step(0, 0, 1, 0, 1, 0, 16'h0,    26'h0,   32'h0,     32'h4,  WB,   0,  32'h0);
        step(0, 0, 0, 0, 0, 0, 16'h0,    26'h0,   32'h0,     32'h8,  WC,   0,  32'h0);
        // jr beats jump; aligned jr in range
        step(0, 0, 0, 1, 1, 1, 16'h1,    26'h3,   32'h0,     32'h0,  WA,   0,  32'h0);
        step(0, 0, 0, 1, 0, 0, 16'h0,    26'h0,   32'hC,     32'hC,  WD,   0,  32'h0);
        // Stalled cycle with a bad jr target never faults
        step(0, 0, 1, 1, 0, 0, 16'h0,    26'h0,   32'h6,     32'hC,  WD,   0,  32'h0);
        step(0, 0, 0, 1, 0, 0, 16'h0,    26'h0,   32'h4,     32'h4,  WB,   0,  32'h0);
        // Misaligned jr faults; fault is sticky and ignores selects/stall
        step(0, 0, 0, 1, 0, 0, 16'h0,    26'h0,   32'h6,     32'h4,  32'h0, 1, 32'h6);
        step(0, 0, 0, 0, 1, 0, 16'h0,    26'h0,   32'h0,     32'h4,  32'h0, 1, 32'h6);
        step(0, 0, 1, 1, 0, 0, 16'h0,    26'h0,   32'h8,     32'h4,  32'h0, 1, 32'h6);
        // Reset out of FAULT, asserted together with stall
        step(0, 1, 1, 0, 0, 0, 16'h0,    26'h0,   32'h0,     32'h0,  WA,   0,  32'h0);
        // Out-of-range jump target on the 256-word unit
        step(0, 0, 0, 0, 1, 0, 16'h0,    26'h100, 32'h0,     32'h0,  32'h0, 1, 32'h400);
        // Out-of-range branch target (wraps below zero)
        step(0, 1, 0, 0, 0, 0, 16'h0,    26'h0,   32'h0,     32'h0,  WA,   0,  32'h0);
        step(0, 0, 0, 0, 0, 1, 16'hFFFE, 26'h0,   32'h0,     32'h0,  32'h0, 1, 32'hFFFF_FFFC);

        // 4-word unit: sequential fetch off the end
        step(1, 1, 0, 0, 0, 0, 16'h0,    26'h0,   32'h0,     32'h0,  WA,   0,  32'h0);
        step(1, 0, 0, 0, 0, 0, 16'h0,    26'h0,   32'h0,     32'h4,  WB,   0,  32'h0);
        step(1, 0, 0, 0, 0, 0, 16'h0,    26'h0,   32'h0,     32'h8,  WC,   0,  32'h0);
        step(1, 0, 0, 0, 0, 0, 16'h0,    26'h0,   32'h0,     32'hC,  WD,   0,  32'h0);
        step(1, 0, 0, 0, 0, 0, 16'h0,    26'h0,   32'h0,     32'hC,  32'h0, 1, 32'h10);
        // New run: jr and jump on the same edge, jr wins
        step(1, 1, 0, 0, 0, 0, 16'h0,    26'h0,   32'h0,     32'h0,  WA,   0,  32'h0);
        step(1, 0, 0, 1, 1, 0, 16'h0,    26'h3,   32'h4,     32'h4,  WB,   0,  32'h0);
        // Jump to the last word, then one word past it
        step(1, 0, 0, 0, 1, 0, 16'h0,    26'h3,   32'h0,     32'hC,  WD,   0,  32'h0);
        step(1, 0, 0, 0, 1, 0, 16'h0,    26'h4,   32'h0,     32'hC,  32'h0, 1, 32'h10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
